dmi_responder: RTL and testbench
================================

DMI_RESPONDER -- requirements
Module: dmi_responder

Interface
REQ-001 SHALL have parameter DMI_ADDR_WIDTH, default 7, DMI address width.
REQ-002 SHALL have parameter DMI_DATA_WIDTH, default 32, DMI data width.
REQ-003 SHALL have parameter DMI_OP_WIDTH, default 2, op/response code width.
REQ-004 SHALL have derived parameters TX_WIDTH = ADDR+DATA+OP (41) and RX_WIDTH = DATA+OP (34).
REQ-005 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port creq_vld, input, 1, request valid.
REQ-008 SHALL have port creq_data, input, TX_WIDTH, request: [40:34] addr, [33:2] data, [1:0] op (0 nop, 1 read, 2 write, 3 reserved).
REQ-009 SHALL have port creq_rdy, output, 1, request ready.
REQ-010 SHALL have port cresp_vld, output, 1, response valid.
REQ-011 SHALL have port cresp_data, output, RX_WIDTH, response: [33:2] data, [1:0] resp (0 success, 2 failed).
REQ-012 SHALL have port cresp_rdy, input, 1, response ready.
REQ-013 SHALL have port hart_halted, input, 1, hart halt status.
REQ-014 SHALL have port dm_haltreq, output, 1, halt request level.
REQ-015 SHALL have port dm_resumereq, output, 1, one-cycle resume pulse.
REQ-016 SHALL have port dm_ndmreset, output, 1, system reset request level.

Function
REQ-017 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; creq_rdy=1 only in IDLE.
REQ-018 SHALL latch creq_data and move IDLE->EXEC on creq_vld && creq_rdy; hold IDLE otherwise.
REQ-019 SHALL perform the register access in EXEC (exactly one cycle), then enter RESP.
REQ-020 SHALL assert cresp_vld in RESP only, cresp_data stable, until cresp_rdy=1; then IDLE; response first visible 2 cycles after acceptance.
REQ-021 SHALL accept a new request in the cycle after the response handshake, never in RESP; no outstanding-request overlap.
REQ-022 SHALL map 0x04 data0 (RW), 0x05 data1 (RW), 0x10 dmcontrol, 0x11 dmstatus (RO).
REQ-023 dmcontrol SHALL hold bit31 haltreq, bit1 ndmreset, bit0 dmactive; bit30 resumereq write-1 SHALL pulse dm_resumereq exactly one cycle (cycle after EXEC), reads as 0.
REQ-024 dmcontrol write with bit0=0 SHALL clear haltreq, ndmreset, data0, data1, regardless of other written bits.
REQ-025 dmstatus read SHALL return bit9 allhalted=hart_halted, bit11 allrunning=~hart_halted, [3:0]=2, other bits 0; writes ignored with resp 0.
REQ-026 read SHALL return register value, resp 0; write and nop SHALL return data 0, resp 0.
REQ-027 unmapped address or op 3 SHALL return data 0, resp 2, no state change.
REQ-028 dm_haltreq/dm_ndmreset SHALL equal the dmcontrol bits combinationally from registers.

Reset
REQ-029 reset SHALL asynchronously force IDLE, creq_rdy=1, cresp_vld=0, cresp_data=0, all registers 0, dm_haltreq=0, dm_resumereq=0, dm_ndmreset=0.
REQ-030 reset during EXEC or RESP SHALL abandon the transaction with no response and no register update.

Configuration
REQ-031 macro DMI_RESPONDER_SCRATCH_EN defined SHALL add four 32-bit RW scratch registers at 0x38-0x3B, reset 0, cleared by dmactive=0.
REQ-032 without DMI_RESPONDER_SCRATCH_EN, 0x38-0x3B SHALL be unmapped (resp 2).

Verification
REQ-033 write 0x04 data 0xDEADBEEF, then read 0x04 -> responses resp 0, read data 0xDEADBEEF, each cresp_vld 2 cycles after accept.
REQ-034 write 0x10 data 0x40000001 -> dm_resumereq high exactly one cycle, dmactive=1; read 0x10 -> 0x00000001.
REQ-035 hart_halted=1, read 0x11 -> data 0x00000202 resp 0; hart_halted=0 -> 0x00000802.
REQ-036 read 0x7F, and op 3 at 0x04 -> resp 2, data 0, registers unchanged; hold cresp_rdy=0 5 cycles -> cresp_vld/data stable, creq_rdy=0.
REQ-037 write 0x10 data 0x80000003, then 0x00000000 -> haltreq/ndmreset set then cleared, data0 cleared to 0.
REQ-038 assert reset while in RESP -> cresp_vld=0 immediately, creq_rdy=1, no response after release; scratch 0x38 write/readback 0x12345678 with macro, resp 2 without.

Source files
------------

// File: rtl/dmi_responder_if.sv
// DMI request/response handshake bundle between a debug transport (master) and the responder (slave).
// Latency: none, wires only.
// Backpressure: creq_rdy gates requests, cresp_rdy holds a pending response.
// Signals: creq_vld/creq_data/creq_rdy request channel, cresp_vld/cresp_data/cresp_rdy response channel.
interface dmi_responder_if #(
    parameter int TX_WIDTH = 41,
    parameter int RX_WIDTH = 34
);
    logic                creq_vld;
    logic [TX_WIDTH-1:0] creq_data;
    logic                creq_rdy;
    logic                cresp_vld;
    logic [RX_WIDTH-1:0] cresp_data;
    logic                cresp_rdy;

    modport master (
        output creq_vld, creq_data, cresp_rdy,
        input  creq_rdy, cresp_vld, cresp_data
    );

    modport slave (
        input  creq_vld, creq_data, cresp_rdy,
        output creq_rdy, cresp_vld, cresp_data
    );
endinterface

// File: rtl/dmi_responder.sv
// Minimal RISC-V debug module register responder: data0/data1, dmcontrol, dmstatus behind a DMI handshake.
// Latency: response valid two cycles after request acceptance (one EXEC cycle, then RESP).
// Backpressure: one transaction in flight; creq_rdy only in IDLE, response held until cresp_rdy.
// Ports: clock/reset (async active-high), dmi (slave modport: creq_*, cresp_*), hart_halted in,
//        dm_haltreq/dm_ndmreset levels and dm_resumereq one-cycle pulse out.
// Option: define DMI_RESPONDER_SCRATCH_EN to add four RW scratch registers at 0x38-0x3B.
module dmi_responder #(
    parameter int DMI_ADDR_WIDTH = 7,
    parameter int DMI_DATA_WIDTH = 32,
    parameter int DMI_OP_WIDTH   = 2,
    parameter int TX_WIDTH       = DMI_ADDR_WIDTH + DMI_DATA_WIDTH + DMI_OP_WIDTH,
    parameter int RX_WIDTH       = DMI_DATA_WIDTH + DMI_OP_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    dmi_responder_if.slave dmi,
    input  logic           hart_halted,
    output logic           dm_haltreq,
    output logic           dm_resumereq,
    output logic           dm_ndmreset
);
    localparam logic [DMI_ADDR_WIDTH-1:0] ADDR_DATA0  = 'h04;
    localparam logic [DMI_ADDR_WIDTH-1:0] ADDR_DATA1  = 'h05;
    localparam logic [DMI_ADDR_WIDTH-1:0] ADDR_DMCTRL = 'h10;
    localparam logic [DMI_ADDR_WIDTH-1:0] ADDR_DMSTAT = 'h11;
`ifdef DMI_RESPONDER_SCRATCH_EN
    localparam logic [DMI_ADDR_WIDTH-1:0] ADDR_SCR0   = 'h38;
    localparam logic [DMI_ADDR_WIDTH-1:0] ADDR_SCR1   = 'h39;
    localparam logic [DMI_ADDR_WIDTH-1:0] ADDR_SCR2   = 'h3A;
    localparam logic [DMI_ADDR_WIDTH-1:0] ADDR_SCR3   = 'h3B;
`endif
    localparam logic [DMI_OP_WIDTH-1:0] OP_READ   = 'd1;
    localparam logic [DMI_OP_WIDTH-1:0] OP_WRITE  = 'd2;
    localparam logic [DMI_OP_WIDTH-1:0] OP_RSVD   = 'd3;
    localparam logic [DMI_OP_WIDTH-1:0] RESP_OK   = 'd0;
    localparam logic [DMI_OP_WIDTH-1:0] RESP_FAIL = 'd2;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                    state_q, state_d;
    logic [TX_WIDTH-1:0]       req_q, req_d;
    logic [RX_WIDTH-1:0]       resp_q, resp_d;
    logic [DMI_DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DMI_DATA_WIDTH-1:0] data1_q, data1_d;
    logic                      haltreq_q, haltreq_d;
    logic                      ndmreset_q, ndmreset_d;
    logic                      dmactive_q, dmactive_d;
    logic                      resume_q, resume_d;
`ifdef DMI_RESPONDER_SCRATCH_EN
    logic [DMI_DATA_WIDTH-1:0] scratch_q [4];
    logic [DMI_DATA_WIDTH-1:0] scratch_d [4];
`endif

    logic [DMI_ADDR_WIDTH-1:0] req_addr;
    logic [DMI_DATA_WIDTH-1:0] req_wdata;
    logic [DMI_OP_WIDTH-1:0]   req_op;
    logic [DMI_DATA_WIDTH-1:0] rdata;
    logic                      hit;

    assign req_addr  = req_q[TX_WIDTH-1 -: DMI_ADDR_WIDTH];
    assign req_wdata = req_q[DMI_OP_WIDTH +: DMI_DATA_WIDTH];
    assign req_op    = req_q[DMI_OP_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        resp_d     = resp_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        haltreq_d  = haltreq_q;
        ndmreset_d = ndmreset_q;
        dmactive_d = dmactive_q;
        resume_d   = 1'b0;
`ifdef DMI_RESPONDER_SCRATCH_EN
        scratch_d  = scratch_q;
`endif
        rdata      = '0;
        hit        = 1'b1;

        // Read-side decode; also tells the write path whether the address exists.
        case (req_addr)
            ADDR_DATA0:  rdata = data0_q;
            ADDR_DATA1:  rdata = data1_q;
            ADDR_DMCTRL: begin
                rdata[DMI_DATA_WIDTH-1] = haltreq_q;
                rdata[1]                = ndmreset_q;
                rdata[0]                = dmactive_q;
            end
            ADDR_DMSTAT: begin
                rdata[11]  = ~hart_halted;
                rdata[9]   = hart_halted;
                rdata[3:0] = 4'd2;
            end
`ifdef DMI_RESPONDER_SCRATCH_EN
            ADDR_SCR0, ADDR_SCR1, ADDR_SCR2, ADDR_SCR3: rdata = scratch_q[req_addr[1:0]];
`endif
            default:     hit = 1'b0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (dmi.creq_vld) begin
                    req_d   = dmi.creq_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                if (!hit || req_op == OP_RSVD) begin
                    resp_d = {{DMI_DATA_WIDTH{1'b0}}, RESP_FAIL};
                end else if (req_op == OP_READ) begin
                    resp_d = {rdata, RESP_OK};
                end else begin
                    resp_d = {{DMI_DATA_WIDTH{1'b0}}, RESP_OK};
                    if (req_op == OP_WRITE) begin
                        case (req_addr)
                            ADDR_DATA0: data0_d = req_wdata;
                            ADDR_DATA1: data1_d = req_wdata;
                            ADDR_DMCTRL: begin
                                if (req_wdata[0]) begin
                                    haltreq_d  = req_wdata[DMI_DATA_WIDTH-1];
                                    ndmreset_d = req_wdata[1];
                                    dmactive_d = 1'b1;
                                    // Resume pulse is visible in the first RESP cycle.
                                    resume_d   = req_wdata[DMI_DATA_WIDTH-2];
                                end else begin
                                    // Deactivating the DM wipes all of its state.
                                    haltreq_d  = 1'b0;
                                    ndmreset_d = 1'b0;
                                    dmactive_d = 1'b0;
                                    data0_d    = '0;
                                    data1_d    = '0;
`ifdef DMI_RESPONDER_SCRATCH_EN
                                    scratch_d  = '{default: '0};
`endif
                                end
                            end
`ifdef DMI_RESPONDER_SCRATCH_EN
                            ADDR_SCR0, ADDR_SCR1, ADDR_SCR2, ADDR_SCR3:
                                scratch_d[req_addr[1:0]] = req_wdata;
`endif
                            default: ; // dmstatus is read-only; writes are accepted and dropped
                        endcase
                    end
                end
            end
            S_RESP: begin
                if (dmi.cresp_rdy) begin
                    state_d = S_IDLE;
                    resp_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            resp_q     <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            haltreq_q  <= 1'b0;
            ndmreset_q <= 1'b0;
            dmactive_q <= 1'b0;
            resume_q   <= 1'b0;
`ifdef DMI_RESPONDER_SCRATCH_EN
            scratch_q  <= '{default: '0};
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            resp_q     <= resp_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            haltreq_q  <= haltreq_d;
            ndmreset_q <= ndmreset_d;
            dmactive_q <= dmactive_d;
            resume_q   <= resume_d;
`ifdef DMI_RESPONDER_SCRATCH_EN
            scratch_q  <= scratch_d;
`endif
        end
    end

    assign dmi.creq_rdy   = (state_q == S_IDLE);
    assign dmi.cresp_vld  = (state_q == S_RESP);
    assign dmi.cresp_data = resp_q;
    assign dm_haltreq     = haltreq_q;
    assign dm_ndmreset    = ndmreset_q;
    assign dm_resumereq   = resume_q;
endmodule

// File: tb/tb_dmi_responder.sv
// Self-checking bench for dmi_responder: directed scenarios followed by random transactions.
// Latency: expects response two cycles after acceptance.
// Backpressure: exercises random cresp_rdy stalls.
module tb_dmi_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic hart_halted = 1'b0;
    logic dm_haltreq, dm_resumereq, dm_ndmreset;

    int n_tests = 0;
    int n_fail  = 0;

    dmi_responder_if #(.TX_WIDTH(41), .RX_WIDTH(34)) dmi ();

    dmi_responder dut (
        .clock        (clock),
        .reset        (reset),
        .dmi          (dmi),
        .hart_halted  (hart_halted),
        .dm_haltreq   (dm_haltreq),
        .dm_resumereq (dm_resumereq),
        .dm_ndmreset  (dm_ndmreset)
    );

    always #5 clock = ~clock;

    // Reference state: register contents as the debugger would see them.
    logic [31:0] m_data0, m_data1;
    logic        m_halt, m_ndm, m_active;
    logic [31:0] m_scr [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data0 = 0; m_data1 = 0; m_halt = 0; m_ndm = 0; m_active = 0;
        for (int i = 0; i < 4; i++) m_scr[i] = 0;
    endtask

    task automatic model(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                         input logic halted, output logic [31:0] ed, output logic [1:0] er,
                         output logic eres);
        logic        mapped;
        logic [31:0] rv;
        int          idx;
        ed = 0; er = 0; eres = 0; mapped = 1; rv = 0; idx = int'(addr) - 'h38;
        if (addr == 7'h04)      rv = m_data0;
        else if (addr == 7'h05) rv = m_data1;
        else if (addr == 7'h10) rv = {m_halt, 29'd0, m_ndm, m_active};
        else if (addr == 7'h11) rv = halted ? 32'h0000_0202 : 32'h0000_0802;
`ifdef DMI_RESPONDER_SCRATCH_EN
        else if (idx >= 0 && idx < 4) rv = m_scr[idx];
`endif
        else mapped = 0;

        if (!mapped || op == 2'd3) begin
            er = 2'd2;
        end else if (op == 2'd1) begin
            ed = rv;
        end else if (op == 2'd2) begin
            if (addr == 7'h04) m_data0 = wd;
            else if (addr == 7'h05) m_data1 = wd;
            else if (addr == 7'h10) begin
                if (wd[0]) begin
                    m_halt = wd[31]; m_ndm = wd[1]; m_active = 1; eres = wd[30];
                end else begin
                    m_halt = 0; m_ndm = 0; m_active = 0; m_data0 = 0; m_data1 = 0;
                    for (int i = 0; i < 4; i++) m_scr[i] = 0;
                end
            end
`ifdef DMI_RESPONDER_SCRATCH_EN
            else if (idx >= 0 && idx < 4) m_scr[idx] = wd;
`endif
        end
    endtask

    // One full transaction, entered and left at a negedge with the DUT idle.
    task automatic txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                       input int stall);
        logic [31:0] ed;
        logic [1:0]  er;
        logic        eres;
        logic [33:0] exp;
        model(op, addr, wd, hart_halted, ed, er, eres);
        exp = {ed, er};
        check("idle_creq_rdy", dmi.creq_rdy, 1'b1);
        dmi.creq_vld  = 1'b1;
        dmi.creq_data = {addr, wd, op};
        @(posedge clock);
        #1;
        dmi.creq_vld  = 1'b0;
        dmi.creq_data = {9'($urandom), $urandom};
        @(negedge clock);
        check("exec_cresp_vld", dmi.cresp_vld, 1'b0);
        check("exec_creq_rdy", dmi.creq_rdy, 1'b0);
        check("exec_resumereq", dm_resumereq, 1'b0);
        @(negedge clock);
        check("resp_cresp_vld", dmi.cresp_vld, 1'b1);
        check("resp_data", dmi.cresp_data, exp);
        check("resp_creq_rdy", dmi.creq_rdy, 1'b0);
        check("resp_resumereq", dm_resumereq, eres);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_cresp_vld", dmi.cresp_vld, 1'b1);
            check("stall_data", dmi.cresp_data, exp);
            check("stall_creq_rdy", dmi.creq_rdy, 1'b0);
            check("stall_resumereq", dm_resumereq, 1'b0);
        end
        dmi.cresp_rdy = 1'b1;
        @(posedge clock);
        #1;
        dmi.cresp_rdy = 1'b0;
        @(negedge clock);
        check("post_cresp_vld", dmi.cresp_vld, 1'b0);
        check("post_creq_rdy", dmi.creq_rdy, 1'b1);
        check("post_resumereq", dm_resumereq, 1'b0);
        check("haltreq_level", dm_haltreq, m_halt);
        check("ndmreset_level", dm_ndmreset, m_ndm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pool [10];
        logic [6:0] a;
        logic [1:0] op;
        logic [31:0] wd;
        pool = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h38, 7'h39, 7'h3A, 7'h3B, 7'h7F, 7'h00};

        dmi.creq_vld = 1'b0; dmi.creq_data = '0; dmi.cresp_rdy = 1'b0;
        model_reset();
        #1;
        check("rst_creq_rdy", dmi.creq_rdy, 1'b1);
        check("rst_cresp_vld", dmi.cresp_vld, 1'b0);
        check("rst_cresp_data", dmi.cresp_data, 34'd0);
        check("rst_haltreq", dm_haltreq, 1'b0);
        check("rst_resumereq", dm_resumereq, 1'b0);
        check("rst_ndmreset", dm_ndmreset, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Basic data0 write/readback and dmcontrol with resume pulse.
        txn(2'd2, 7'h04, 32'hDEAD_BEEF, 0);
        txn(2'd1, 7'h04, 32'h0, 0);
        txn(2'd2, 7'h10, 32'h4000_0001, 0);
        txn(2'd1, 7'h10, 32'h0, 0);
        hart_halted = 1'b1;
        txn(2'd1, 7'h11, 32'h0, 0);
        hart_halted = 1'b0;
        txn(2'd1, 7'h11, 32'h0, 1);
        txn(2'd2, 7'h11, 32'hFFFF_FFFF, 0);
        // Unmapped and reserved op, with a long response stall.
        txn(2'd1, 7'h7F, 32'h0, 5);
        txn(2'd3, 7'h04, 32'h1111_1111, 5);
        txn(2'd1, 7'h04, 32'h0, 0);
        txn(2'd0, 7'h05, 32'h2222_2222, 0);
        // Halt/ndmreset set, then DM deactivation clears everything.
        txn(2'd2, 7'h10, 32'h8000_0003, 0);
        txn(2'd2, 7'h10, 32'h0000_0000, 0);
        txn(2'd1, 7'h04, 32'h0, 0);
        // Scratch register (mapped only with the option enabled).
        txn(2'd2, 7'h10, 32'h0000_0001, 0);
        txn(2'd2, 7'h38, 32'h1234_5678, 0);
        txn(2'd1, 7'h38, 32'h0, 0);

        // Reset while a response is pending.
        txn(2'd2, 7'h10, 32'h8000_0003, 0);
        txn(2'd2, 7'h05, 32'hCAFE_F00D, 0);
        dmi.creq_vld = 1'b1; dmi.creq_data = {7'h05, 32'h0, 2'd1};
        @(posedge clock);
        #1 dmi.creq_vld = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_rst_cresp_vld", dmi.cresp_vld, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_cresp_vld", dmi.cresp_vld, 1'b0);
        check("mid_rst_creq_rdy", dmi.creq_rdy, 1'b1);
        check("mid_rst_cresp_data", dmi.cresp_data, 34'd0);
        check("mid_rst_haltreq", dm_haltreq, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        dmi.cresp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("after_rst_no_resp", dmi.cresp_vld, 1'b0);
        end
        dmi.cresp_rdy = 1'b0;
        txn(2'd1, 7'h05, 32'h0, 0);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            a  = ($urandom_range(0, 9) == 9) ? 7'($urandom) : pool[$urandom_range(0, 9)];
            op = 2'($urandom);
            wd = $urandom;
            if (a == 7'h10 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            hart_halted = 1'($urandom);
            txn(op, a, wd, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
